// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and controller state encodings.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per step, product in a 2*DATA_WIDTH accumulator.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_step,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic                    o_done,
  output logic [2*DATA_WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH:0]     hi_sum;
  logic [2*DATA_WIDTH-1:0] acc_step;

  // Upper half gathers partial products while the multiplier drains out of the lower half.
  assign hi_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {hi_sum, acc_q[DATA_WIDTH-1:1]};

  assign o_done    = i_step && (cnt_q == '0);
  assign o_product = acc_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (i_start) begin
      acc_q   <= {{DATA_WIDTH{1'b0}}, i_b};
      mcand_q <= i_a;
      cnt_q   <= CNT_W'(DATA_WIDTH - 1);
    end else if (i_step) begin
      acc_q <= acc_step;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready operand handshake, single-cycle logic/arith ops,
// sequential MUL, registered result with a one-cycle o_valid pulse and C/Z/N/V flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [2:0]            i_op,
  input  logic                  i_flags_wr_en,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry_flag,
  output logic                  o_zero_flag,
  output logic                  o_neg_flag,
  output logic                  o_ovf_flag
);

  localparam int W = DATA_WIDTH;

  alu_state_e              state_q, state_d;
  alu_op_e                 op;
  logic                    accept, mul_start, mul_step, mul_done;
  logic [2*W-1:0]          mul_product;
  logic                    flags_wr_q;
  logic [SHAMT_W-1:0]      shamt;
  logic [W:0]              sum, diff, shl_ext, shr_ext;
  logic [W-1:0]            alu_res;
  logic                    alu_c, alu_v;
  logic                    cmp_valid, cmp_c, cmp_v, cmp_we;
  logic [W-1:0]            cmp_res;

  assign op       = alu_op_e'(i_op);
  assign o_ready  = (state_q == IDLE) && !i_rst;
  assign accept   = i_valid && o_ready;
  assign mul_step = (state_q == MUL);
  assign shamt    = i_b[SHAMT_W-1:0];

  // Extra top bit carries the last bit shifted out (SHL) or the carry/borrow (ADD/SUB).
  assign sum     = {1'b0, i_a} + {1'b0, i_b};
  assign diff    = {1'b0, i_a} - {1'b0, i_b};
  assign shl_ext = {1'b0, i_a} << shamt;
  assign shr_ext = {i_a, 1'b0} >> shamt;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (i_a[W-1] == i_b[W-1]) && (sum[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = !diff[W];
        alu_v   = (i_a[W-1] != i_b[W-1]) && (diff[W-1] != i_a[W-1]);
      end
      OP_AND: alu_res = i_a & i_b;
      OP_OR:  alu_res = i_a | i_b;
      OP_XOR: alu_res = i_a ^ i_b;
      OP_SHL: begin
        alu_res = shl_ext[W-1:0];
        alu_c   = shl_ext[W];
      end
      OP_SHR: begin
        alu_res = shr_ext[W:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (accept && op == OP_MUL) begin
        state_d   = MUL;
        mul_start = 1'b1;
      end
      MUL:  if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion source: MUL finishing in its own state, or a non-MUL op at its accept edge.
  always_comb begin
    cmp_valid = 1'b0;
    cmp_res   = alu_res;
    cmp_c     = alu_c;
    cmp_v     = alu_v;
    cmp_we    = i_flags_wr_en;
    if (mul_done) begin
      cmp_valid = 1'b1;
      cmp_res   = mul_product[W-1:0];
      cmp_c     = |mul_product[2*W-1:W];
      cmp_v     = 1'b0;
      cmp_we    = flags_wr_q;
    end else if (accept && op != OP_MUL) begin
      cmp_valid = 1'b1;
    end
  end

  alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (mul_start),
    .i_step    (mul_step),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_done    (mul_done),
    .o_product (mul_product)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      flags_wr_q   <= 1'b0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_carry_flag <= 1'b0;
      o_zero_flag  <= 1'b0;
      o_neg_flag   <= 1'b0;
      o_ovf_flag   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_valid <= cmp_valid;
      if (accept) flags_wr_q <= i_flags_wr_en;
      if (cmp_valid) begin
        o_result <= cmp_res;
        if (cmp_we) begin
          o_carry_flag <= cmp_c;
          o_zero_flag  <= (cmp_res == '0);
          o_neg_flag   <= cmp_res[W-1];
          o_ovf_flag   <= cmp_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed literal cases plus randomized traffic checked every cycle
// against an arithmetic reference model.
module tb_alu_mc;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [2:0]   i_op = '0;
  logic         i_flags_wr_en = 1'b0;
  logic         o_ready, o_valid;
  logic [W-1:0] o_result;
  logic         o_carry_flag, o_zero_flag, o_neg_flag, o_ovf_flag;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_op          (i_op),
    .i_flags_wr_en (i_flags_wr_en),
    .o_valid       (o_valid),
    .o_result      (o_result),
    .o_carry_flag  (o_carry_flag),
    .o_zero_flag   (o_zero_flag),
    .o_neg_flag    (o_neg_flag),
    .o_ovf_flag    (o_ovf_flag)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sx(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic void ref_op(input int op, input int a, input int b,
                                 output int r, output bit c, output bit v);
    int s, t, p;
    s = b % W;
    c = 0;
    v = 0;
    case (op)
      0: begin t = a + b; r = t & MASK; c = (t > MASK);
               t = sx(a) + sx(b); v = (t > (MASK >> 1)) || (t < -(1 << (W - 1))); end
      1: begin r = (a - b) & MASK; c = (a >= b);
               t = sx(a) - sx(b); v = (t > (MASK >> 1)) || (t < -(1 << (W - 1))); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << s) & MASK; c = (s == 0) ? 0 : ((a >> (W - s)) & 1) != 0; end
      6: begin r = a >> s;          c = (s == 0) ? 0 : ((a >> (s - 1)) & 1) != 0; end
      default: begin p = a * b; r = p & MASK; c = (p >> W) != 0; end
    endcase
  endfunction

  bit m_idle = 1;
  int m_left = 0;
  bit e_valid = 0, e_c = 0, e_z = 0, e_n = 0, e_v = 0;
  int e_res = 0;
  int p_res;
  bit p_c, p_v, p_we;

  function automatic void complete(input int r, input bit c, input bit v, input bit we);
    e_valid = 1;
    e_res   = r;
    if (we) begin
      e_c = c;
      e_z = (r == 0);
      e_n = ((r >> (W - 1)) & 1) != 0;
      e_v = v;
    end
  endfunction

  always @(posedge i_clk) begin
    int r;
    bit c, v;
    if (i_rst) begin
      m_idle = 1; m_left = 0; e_valid = 0; e_res = 0;
      e_c = 0; e_z = 0; e_n = 0; e_v = 0;
    end else begin
      e_valid = 0;
      if (!m_idle) begin
        m_left--;
        if (m_left == 0) begin
          complete(p_res, p_c, p_v, p_we);
          m_idle = 1;
        end
      end else if (i_valid) begin
        ref_op(int'(i_op), int'(i_a), int'(i_b), r, c, v);
        if (i_op == 3'd7) begin
          m_idle = 0; m_left = W;
          p_res = r; p_c = c; p_v = v; p_we = i_flags_wr_en;
        end else begin
          complete(r, c, v, i_flags_wr_en);
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("m_valid",  o_valid,      e_valid);
      check("m_ready",  o_ready,      m_idle && !i_rst);
      check("m_result", o_result,     e_res);
      check("m_carry",  o_carry_flag, e_c);
      check("m_zero",   o_zero_flag,  e_z);
      check("m_neg",    o_neg_flag,   e_n);
      check("m_ovf",    o_ovf_flag,   e_v);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(output int lat, output int rdy_low);
    lat = 1;
    rdy_low = 0;
    while (1) begin
      if (!o_ready) rdy_low++;
      if (o_valid || lat >= 20) break;
      @(posedge i_clk); #2;
      lat++;
    end
    check("done_seen", o_valid, 1'b1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic we, output int lat);
    int rl;
    @(posedge i_clk); #2;
    i_valid = 1; i_op = op; i_a = a; i_b = b; i_flags_wr_en = we;
    @(posedge i_clk); #2;
    i_valid = 0;
    wait_done(lat, rl);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] r,
                           input logic c, input logic z, input logic n, input logic v);
    check({name, "_res"}, o_result, r);
    check({name, "_cznv"}, {o_carry_flag, o_zero_flag, o_neg_flag, o_ovf_flag}, {c, z, n, v});
  endtask

  initial begin
    int lat, rl;
    logic [2:0]   bop[4];
    logic [W-1:0] ba[4], bb[4], bres[4];
    logic [W-1:0] picks[4];

    bop  = '{3'd0, 3'd2, 3'd3, 3'd1};
    ba   = '{8'h03, 8'hF0, 8'h0F, 8'h05};
    bb   = '{8'h04, 8'h3C, 8'h30, 8'h06};
    bres = '{8'h07, 8'h30, 8'h3F, 8'hFF};
    picks = '{8'h00, 8'hFF, 8'h80, 8'h7F};

    @(posedge i_clk);
    chk_en = 1;
    @(posedge i_clk); #2;
    check("rst_ready", o_ready, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check_out("rst", 8'h00, 0, 0, 0, 0);
    i_rst = 0;
    #1 check("ready_after_rst", o_ready, 1'b1);

    issue(3'd0, 8'hFF, 8'h01, 1, lat);
    check("add_lat", lat, 1);
    check_out("add", 8'h00, 1, 1, 0, 0);

    issue(3'd1, 8'h80, 8'h01, 1, lat);
    check_out("sub1", 8'h7F, 1, 0, 0, 1);
    issue(3'd1, 8'h01, 8'h02, 1, lat);
    check_out("sub2", 8'hFF, 0, 0, 1, 0);

    // MUL with i_valid held high throughout: the ADD behind it must wait.
    @(posedge i_clk); #2;
    i_valid = 1; i_op = 3'd7; i_a = 8'h10; i_b = 8'h11; i_flags_wr_en = 1;
    @(posedge i_clk); #2;
    i_op = 3'd0; i_a = 8'h01; i_b = 8'h01;
    wait_done(lat, rl);
    i_valid = 0;
    check("mul_lat", lat, 9);
    check("mul_ready_low", rl, 8);
    check_out("mul", 8'h10, 1, 0, 0, 0);

    issue(3'd5, 8'h81, 8'h01, 1, lat);
    check_out("shl", 8'h02, 1, 0, 0, 0);
    issue(3'd6, 8'h81, 8'h00, 1, lat);
    check_out("shr", 8'h81, 0, 0, 1, 0);
    issue(3'd4, 8'hF0, 8'hF0, 0, lat);
    check_out("xor_nowr", 8'h00, 0, 0, 1, 0);

    // Four single-cycle ops on consecutive edges.
    @(posedge i_clk); #2;
    i_valid = 1; i_flags_wr_en = 1;
    i_op = bop[0]; i_a = ba[0]; i_b = bb[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #2;
      if (i < 3) begin
        i_op = bop[i+1]; i_a = ba[i+1]; i_b = bb[i+1];
      end else begin
        i_valid = 0;
      end
      check($sformatf("b2b%0d_valid", i), o_valid, 1'b1);
      check($sformatf("b2b%0d_res", i), o_result, bres[i]);
    end

    // Reset three cycles into a MUL.
    @(posedge i_clk); #2;
    i_valid = 1; i_op = 3'd7; i_a = 8'h03; i_b = 8'h05;
    @(posedge i_clk); #2;
    i_valid = 0;
    repeat (3) @(posedge i_clk);
    #2 i_rst = 1;
    @(posedge i_clk); #2;
    check("mulrst_valid", o_valid, 1'b0);
    check("mulrst_ready", o_ready, 1'b0);
    check_out("mulrst", 8'h00, 0, 0, 0, 0);
    i_rst = 0;
    @(posedge i_clk); #2;
    check("mulrst_ready_after", o_ready, 1'b1);
    check("mulrst_no_valid", o_valid, 1'b0);
    repeat (12) @(posedge i_clk);

    // Randomized traffic, including ops offered while busy and occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(posedge i_clk); #2;
      i_rst         = ($urandom_range(0, 63) == 0);
      i_valid       = ($urandom_range(0, 3) != 0);
      i_op          = 3'($urandom_range(0, 7));
      i_a           = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
      i_b           = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
      i_flags_wr_en = 1'($urandom_range(0, 1));
    end
    @(posedge i_clk); #2;
    i_rst = 0;
    i_valid = 0;
    repeat (12) @(posedge i_clk);
    @(negedge i_clk);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
